// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Types and constants shared by the RV32I execute stage and its ALU.
//   XLEN / REG_ADDR_W : datapath width and register index width
//   alu_op_e          : 3-bit ALU operation select
//   fwd_sel_e         : operand forwarding select (11 is reserved = no forward)
//   result_src_e      : write-back result source
//   F3_*              : branch funct3 encodings understood by the EX stage
// -----------------------------------------------------------------------------
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

endpackage

// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu
// Purely combinational XLEN-bit ALU for the execute stage.
//   SrcA, SrcB  : operands
//   ALUControl  : operation (alu_op_e encoding)
//   ALUResult   : result, wraps modulo 2^XLEN
//   Zero        : ALUResult == 0
// -----------------------------------------------------------------------------
module alu #(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic [2:0]      ALUControl,
  output logic [XLEN-1:0] ALUResult,
  output logic            Zero
);
  import riscv_pkg::*;

  logic slt_bit;

  assign slt_bit = ($signed(SrcA) < $signed(SrcB));

  always_comb begin
    ALUResult = '0;
    case (alu_op_e'(ALUControl))
      ALU_ADD: ALUResult = SrcA + SrcB;
      ALU_SUB: ALUResult = SrcA - SrcB;
      ALU_AND: ALUResult = SrcA & SrcB;
      ALU_OR:  ALUResult = SrcA | SrcB;
      ALU_XOR: ALUResult = SrcA ^ SrcB;
      ALU_SLT: ALUResult = {{(XLEN-1){1'b0}}, slt_bit};
      // Only the low five bits of SrcB are a shift amount; upper bits ignored.
      ALU_SLL: ALUResult = SrcA << SrcB[4:0];
      ALU_SRL: ALUResult = SrcA >> SrcB[4:0];
    endcase
  end

  assign Zero = (ALUResult == '0);

endmodule

// File: rtl/execute_stage.sv
// -----------------------------------------------------------------------------
// execute_stage
// RV32I EX stage plus the EX/MEM pipeline register.
//   Inputs : ID/EX values (RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, RD_E),
//            control (ALUControlE, ALUSrcE, Funct3_E, BranchE, JumpE,
//            RegWriteE, MemWriteE, ResultSrcE), forwarding selects
//            (ForwardAE, ForwardBE) and the WB-stage ResultW.
//   Outputs: PCSrcE / PCTargetE (combinational fetch redirect) and the
//            registered M-stage values (*M). ALUResultM also feeds back into
//            this stage's own operand muxes for back-to-back dependencies.
// Reset clears every M register; RegWriteM = MemWriteM = 0 is a bubble.
// -----------------------------------------------------------------------------
module execute_stage #(
  parameter int XLEN       = riscv_pkg::XLEN,
  parameter int REG_ADDR_W = riscv_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [XLEN-1:0]       RD1_E,
  input  logic [XLEN-1:0]       RD2_E,
  input  logic [XLEN-1:0]       Imm_Ext_E,
  input  logic [XLEN-1:0]       PCE,
  input  logic [XLEN-1:0]       PCPlus4E,
  input  logic [REG_ADDR_W-1:0] RD_E,
  input  logic [2:0]            ALUControlE,
  input  logic                  ALUSrcE,
  input  logic [2:0]            Funct3_E,
  input  logic                  BranchE,
  input  logic                  JumpE,
  input  logic                  RegWriteE,
  input  logic                  MemWriteE,
  input  logic [1:0]            ResultSrcE,
  input  logic [1:0]            ForwardAE,
  input  logic [1:0]            ForwardBE,
  input  logic [XLEN-1:0]       ResultW,
  output logic                  PCSrcE,
  output logic [XLEN-1:0]       PCTargetE,
  output logic [XLEN-1:0]       ALUResultM,
  output logic [XLEN-1:0]       WriteDataM,
  output logic [REG_ADDR_W-1:0] RD_M,
  output logic [XLEN-1:0]       PCPlus4M,
  output logic                  RegWriteM,
  output logic                  MemWriteM,
  output logic [1:0]            ResultSrcM
);
  import riscv_pkg::*;

  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] srcb_fwd;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] alu_result;
  logic            alu_zero_unused;
  logic            branch_cond;

  logic [XLEN-1:0]       alu_result_q, alu_result_d;
  logic [XLEN-1:0]       write_data_q, write_data_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic [XLEN-1:0]       pc_plus4_q, pc_plus4_d;
  logic                  reg_write_q, reg_write_d;
  logic                  mem_write_q, mem_write_d;
  logic [1:0]            result_src_q, result_src_d;

  // Forwarding muxes. Select 11 is reserved and behaves like "no forward".
  // The MEM-stage source is this stage's own EX/MEM register.
  always_comb begin
    src_a = RD1_E;
    case (ForwardAE)
      FWD_WB:  src_a = ResultW;
      FWD_MEM: src_a = alu_result_q;
      default: src_a = RD1_E;
    endcase
  end

  always_comb begin
    srcb_fwd = RD2_E;
    case (ForwardBE)
      FWD_WB:  srcb_fwd = ResultW;
      FWD_MEM: srcb_fwd = alu_result_q;
      default: srcb_fwd = RD2_E;
    endcase
  end

  assign src_b = ALUSrcE ? Imm_Ext_E : srcb_fwd;

  alu #(
    .XLEN(XLEN)
  ) u_alu (
    .SrcA       (src_a),
    .SrcB       (src_b),
    .ALUControl (ALUControlE),
    .ALUResult  (alu_result),
    .Zero       (alu_zero_unused)
  );

  // Branch compare works on the register operands (SrcB before the immediate
  // mux), so it is independent of whatever the ALU is computing.
  always_comb begin
    branch_cond = 1'b0;
    case (Funct3_E)
      F3_BEQ:  branch_cond = (src_a == srcb_fwd);
      F3_BNE:  branch_cond = (src_a != srcb_fwd);
      F3_BLT:  branch_cond = ($signed(src_a) <  $signed(srcb_fwd));
      F3_BGE:  branch_cond = ($signed(src_a) >= $signed(srcb_fwd));
      default: branch_cond = 1'b0;
    endcase
  end

  assign PCTargetE = PCE + Imm_Ext_E;
  assign PCSrcE    = JumpE | (BranchE & branch_cond);

  // EX/MEM register: free-running, no stall or enable.
  always_comb begin
    alu_result_d = alu_result;
    write_data_d = srcb_fwd;   // store data never takes the immediate
    rd_d         = RD_E;
    pc_plus4_d   = PCPlus4E;
    reg_write_d  = RegWriteE;
    mem_write_d  = MemWriteE;
    result_src_d = ResultSrcE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_result_q <= '0;
      write_data_q <= '0;
      rd_q         <= '0;
      pc_plus4_q   <= '0;
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      result_src_q <= RES_ALU;
    end else begin
      alu_result_q <= alu_result_d;
      write_data_q <= write_data_d;
      rd_q         <= rd_d;
      pc_plus4_q   <= pc_plus4_d;
      reg_write_q  <= reg_write_d;
      mem_write_q  <= mem_write_d;
      result_src_q <= result_src_d;
    end
  end

  assign ALUResultM = alu_result_q;
  assign WriteDataM = write_data_q;
  assign RD_M       = rd_q;
  assign PCPlus4M   = pc_plus4_q;
  assign RegWriteM  = reg_write_q;
  assign MemWriteM  = mem_write_q;
  assign ResultSrcM = result_src_q;

endmodule

// File: tb/tb_execute_stage.sv
// -----------------------------------------------------------------------------
// tb_execute_stage
// Directed plus random stimulus for execute_stage, checked against a
// behavioural model of the EX stage arithmetic and the EX/MEM register.
// -----------------------------------------------------------------------------
module tb_execute_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
  logic [4:0]  RD_E;
  logic [2:0]  ALUControlE, Funct3_E;
  logic        ALUSrcE, BranchE, JumpE, RegWriteE, MemWriteE;
  logic [1:0]  ResultSrcE, ForwardAE, ForwardBE;
  logic        PCSrcE;
  logic [31:0] PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RD_M;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;

  int checks = 0;
  int errors = 0;

  // Model of the EX/MEM register contents.
  logic [31:0] m_alu, m_wd, m_pc4;
  logic [4:0]  m_rd;
  logic        m_rw, m_mw;
  logic [1:0]  m_rs;

  execute_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .RD1_E      (RD1_E),
    .RD2_E      (RD2_E),
    .Imm_Ext_E  (Imm_Ext_E),
    .PCE        (PCE),
    .PCPlus4E   (PCPlus4E),
    .RD_E       (RD_E),
    .ALUControlE(ALUControlE),
    .ALUSrcE    (ALUSrcE),
    .Funct3_E   (Funct3_E),
    .BranchE    (BranchE),
    .JumpE      (JumpE),
    .RegWriteE  (RegWriteE),
    .MemWriteE  (MemWriteE),
    .ResultSrcE (ResultSrcE),
    .ForwardAE  (ForwardAE),
    .ForwardBE  (ForwardBE),
    .ResultW    (ResultW),
    .PCSrcE     (PCSrcE),
    .PCTargetE  (PCTargetE),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .RD_M       (RD_M),
    .PCPlus4M   (PCPlus4M),
    .RegWriteM  (RegWriteM),
    .MemWriteM  (MemWriteM),
    .ResultSrcM (ResultSrcM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_fwd(input logic [1:0] sel, input logic [31:0] reg_val,
                                          input logic [31:0] wb_val, input logic [31:0] mem_val);
    if (sel == 2'd1)      return wb_val;
    else if (sel == 2'd2) return mem_val;
    else                  return reg_val;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    int unsigned sh;
    sa = a;
    sb = b;
    sh = b % 32;
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return (sa < sb) ? 32'd1 : 32'd0;
      3'd6:    return a << sh;
      default: return a >> sh;
    endcase
  endfunction

  function automatic logic ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return sa < sb;
      3'd5:    return sa >= sb;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    m_alu = '0; m_wd = '0; m_pc4 = '0; m_rd = '0;
    m_rw = 1'b0; m_mw = 1'b0; m_rs = '0;
  endtask

  task automatic chk_m(input string tag);
    chk({tag, ".ALUResultM"}, ALUResultM, m_alu);
    chk({tag, ".WriteDataM"}, WriteDataM, m_wd);
    chk({tag, ".RD_M"},       {27'd0, RD_M}, {27'd0, m_rd});
    chk({tag, ".PCPlus4M"},   PCPlus4M, m_pc4);
    chk({tag, ".RegWriteM"},  {31'd0, RegWriteM}, {31'd0, m_rw});
    chk({tag, ".MemWriteM"},  {31'd0, MemWriteM}, {31'd0, m_mw});
    chk({tag, ".ResultSrcM"}, {30'd0, ResultSrcM}, {30'd0, m_rs});
  endtask

  task automatic zero_inputs();
    RD1_E = '0; RD2_E = '0; Imm_Ext_E = '0; PCE = '0; PCPlus4E = '0; ResultW = '0;
    RD_E = '0; ALUControlE = '0; Funct3_E = 3'd2; ALUSrcE = 0; BranchE = 0; JumpE = 0;
    RegWriteE = 0; MemWriteE = 0; ResultSrcE = '0; ForwardAE = '0; ForwardBE = '0;
  endtask

  task automatic rand_inputs();
    RD1_E = $urandom; RD2_E = $urandom; Imm_Ext_E = $urandom; PCE = $urandom;
    PCPlus4E = $urandom; ResultW = $urandom; RD_E = 5'($urandom);
    ALUControlE = 3'($urandom); Funct3_E = 3'($urandom); ALUSrcE = 1'($urandom);
    BranchE = 1'($urandom); JumpE = 1'($urandom_range(0, 3) == 0);
    RegWriteE = 1'($urandom); MemWriteE = 1'($urandom); ResultSrcE = 2'($urandom_range(0, 2));
    ForwardAE = 2'($urandom); ForwardBE = 2'($urandom);
    // Occasionally make the branch operands equal to exercise beq/bge edges.
    if ($urandom_range(0, 3) == 0) begin
      RD2_E = RD1_E; ForwardAE = 2'd0; ForwardBE = 2'd0;
    end
  endtask

  // One instruction through EX: check the combinational outputs, clock it,
  // then check the registered M outputs. Entered and left at posedge+1.
  task automatic cycle(input string tag);
    logic [31:0] a, bf, b, res;
    #1;
    a   = ref_fwd(ForwardAE, RD1_E, ResultW, m_alu);
    bf  = ref_fwd(ForwardBE, RD2_E, ResultW, m_alu);
    b   = ALUSrcE ? Imm_Ext_E : bf;
    res = ref_alu(ALUControlE, a, b);
    chk({tag, ".PCTargetE"}, PCTargetE, PCE + Imm_Ext_E);
    chk({tag, ".PCSrcE"}, {31'd0, PCSrcE},
        {31'd0, JumpE | (BranchE & ref_taken(Funct3_E, a, bf))});
    @(posedge clk);
    m_alu = res; m_wd = bf; m_pc4 = PCPlus4E; m_rd = RD_E;
    m_rw = RegWriteE; m_mw = MemWriteE; m_rs = ResultSrcE;
    #1;
    chk_m(tag);
  endtask

  logic [31:0] fwd_exp [4];
  logic [1:0]  fwd_sel [4];

  initial begin
    fwd_exp[0] = 32'd6;  fwd_exp[1] = 32'd8;  fwd_exp[2] = 32'd10; fwd_exp[3] = 32'd6;
    fwd_sel[0] = 2'b00;  fwd_sel[1] = 2'b01;  fwd_sel[2] = 2'b10;  fwd_sel[3] = 2'b11;

    // ---------------- reset held across 3 edges ----------------
    rst_n = 1'b0;
    rand_inputs();
    RegWriteE = 1'b1; MemWriteE = 1'b1;
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    chk_m("reset_hold");
    chk("reset_hold.PCTargetE", PCTargetE, PCE + Imm_Ext_E);
    rst_n = 1'b1;

    // ---------------- forwarding sweep ----------------
    for (int i = 0; i < 4; i++) begin
      zero_inputs();
      RD1_E = 32'd4; RD2_E = 32'd5; RegWriteE = 1'b1;
      cycle("fwd_setup");
      chk("fwd_setup.ALUResultM=9", ALUResultM, 32'd9);
      RD1_E = 32'd5; RD2_E = 32'd1; ResultW = 32'd7; ForwardAE = fwd_sel[i];
      cycle("fwd");
      chk($sformatf("fwd_sel%0d", i), ALUResultM, fwd_exp[i]);
    end

    // ---------------- store data ----------------
    zero_inputs();
    RD1_E = 32'h0000_1000; RD2_E = 32'h1234_5678;
    ALUSrcE = 1'b1; Imm_Ext_E = 32'd16; ForwardBE = 2'b01; ResultW = 32'hDEAD_BEEF;
    MemWriteE = 1'b1;
    cycle("store");
    chk("store.WriteDataM", WriteDataM, 32'hDEAD_BEEF);
    chk("store.ALUResultM", ALUResultM, 32'h0000_1010);
    chk("store.MemWriteM", {31'd0, MemWriteM}, 32'd1);

    // ---------------- branches ----------------
    zero_inputs();
    PCE = 32'h100; Imm_Ext_E = 32'hFFFF_FFF8; BranchE = 1'b1;
    RD1_E = 32'd3; RD2_E = 32'd3; Funct3_E = 3'b000;
    #1;
    chk("beq.PCSrcE", {31'd0, PCSrcE}, 32'd1);
    chk("beq.PCTargetE", PCTargetE, 32'hF8);
    cycle("beq");
    Funct3_E = 3'b001;
    #1;
    chk("bne.PCSrcE", {31'd0, PCSrcE}, 32'd0);
    chk("bne.PCTargetE", PCTargetE, 32'hF8);
    cycle("bne");
    RD1_E = 32'hFFFF_FFFF; RD2_E = 32'd1; Funct3_E = 3'b100;
    #1;
    chk("blt.PCSrcE", {31'd0, PCSrcE}, 32'd1);
    chk("blt.PCTargetE", PCTargetE, 32'hF8);
    cycle("blt");

    // ---------------- ALU edge cases ----------------
    zero_inputs();
    RD1_E = 32'hFFFF_FFFF; RD2_E = 32'd1; ALUControlE = 3'd0;
    #1;
    chk("add_wrap.Zero", {31'd0, dut.u_alu.Zero}, 32'd1);
    cycle("add_wrap");
    chk("add_wrap.ALUResultM", ALUResultM, 32'd0);
    RD1_E = 32'h8000_0000; RD2_E = 32'd0; ALUControlE = 3'd5;
    cycle("slt");
    chk("slt.ALUResultM", ALUResultM, 32'd1);
    RD1_E = 32'd1; ALUSrcE = 1'b1; Imm_Ext_E = 32'd33; ALUControlE = 3'd6;
    cycle("sll33");
    chk("sll33.ALUResultM", ALUResultM, 32'd2);
    RD1_E = 32'h8000_0000; ALUSrcE = 1'b0; RD2_E = 32'd31; ALUControlE = 3'd7;
    cycle("srl31");
    chk("srl31.ALUResultM", ALUResultM, 32'd1);

    // ---------------- jal then back-to-back dependency ----------------
    zero_inputs();
    JumpE = 1'b1; PCE = 32'h200; PCPlus4E = 32'h204; Imm_Ext_E = 32'h40;
    ResultSrcE = 2'b10; RegWriteE = 1'b1; RD_E = 5'd1;
    RD1_E = 32'h40; RD2_E = 32'h2;
    #1;
    chk("jal.PCSrcE", {31'd0, PCSrcE}, 32'd1);
    cycle("jal");
    chk("jal.PCPlus4M", PCPlus4M, 32'h204);
    chk("jal.ResultSrcM", {30'd0, ResultSrcM}, 32'd2);
    zero_inputs();
    ForwardAE = 2'b10; RD1_E = 32'hFFFF_0000; RD2_E = 32'd1; RegWriteE = 1'b1;
    cycle("dep");
    chk("dep.ALUResultM", ALUResultM, 32'h43);

    // ---------------- x0 destination passes through ----------------
    zero_inputs();
    RD_E = 5'd0; RegWriteE = 1'b1; RD1_E = 32'd77;
    cycle("x0");
    chk("x0.RegWriteM", {31'd0, RegWriteM}, 32'd1);

    // ---------------- random instructions ----------------
    for (int n = 0; n < 80; n++) begin
      rand_inputs();
      cycle("rand");
    end

    // ---------------- asynchronous reset mid-cycle ----------------
    rand_inputs();
    RegWriteE = 1'b1; MemWriteE = 1'b1; PCPlus4E = 32'h0000_0A04;
    cycle("pre_async");
    #2;
    rst_n = 1'b0;
    clear_model();
    #1;
    chk_m("async_reset");
    chk("async_reset.PCTargetE", PCTargetE, PCE + Imm_Ext_E);
    @(posedge clk);
    #1;
    chk_m("async_reset_edge");
    rst_n = 1'b1;

    // Post-release: pipeline restarts cleanly.
    for (int n = 0; n < 10; n++) begin
      rand_inputs();
      cycle("post_reset");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
